tpu_result_deskew: RTL and testbench

- Receiving end of the systolic array's bottom-row output interface: captures the normalized 8-bit results from bottom-row PEs (3,0)..(3,3).
- Those results leave the array on the same diagonal skew the feeder applies on input, one column later per column index.
- The block removes the skew, reassembles whole result rows and buffers them in a small FIFO.
- Rows are presented downstream (image writer / DMA) on a valid/ready handshake, with per-tile sequencing and an overflow error flag.

---
 rtl/tpu_pkg.sv | 21 ++
 rtl/tpu_row_fifo.sv | 72 +++++++
 rtl/tpu_result_deskew.sv | 158 +++++++++++++++
 tb/tb_tpu_result_deskew.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared types and defaults for the systolic array result path
//
// Purpose: default array geometry, the packed result-row type and the
// deskew controller state encoding, shared by the deskew block and the
// row FIFO (which is also reused on the input feeder side).
package tpu_pkg;

  localparam int TPU_DEPTH  = 4;  // bottom-row PEs (array columns)
  localparam int TPU_DATA_W = 8;  // one normalized PE output

  // One aligned result row; column 0 occupies the least significant byte.
  typedef logic [TPU_DEPTH-1:0][TPU_DATA_W-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    COLLECT,
    DONE
  } state_t;

endpackage

// File: rtl/tpu_row_fifo.sv
// rtl/tpu_row_fifo.sv - synchronous row FIFO with count and same-cycle push/pop
//
// Purpose: buffers whole rows between the array and its consumer.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   push, push_data write request and row
//   pop             read request (ignored when empty)
//   head            row at the head, zero when empty
//   full, empty     occupancy flags
//   count           rows held (0..FIFO_DEPTH)
module tpu_row_fifo #(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(FIFO_DEPTH));

  // A pop frees a slot in the same cycle, so a full FIFO can still accept
  // a push when it is being drained simultaneously.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head = empty ? '0 : mem[rd_ptr];

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tpu_result_deskew.sv
// rtl/tpu_result_deskew.sv - removes diagonal skew from bottom-row PE results
//
// Purpose: realigns the skewed column outputs of the array's bottom row into
// whole result rows, buffers them and presents them on a valid/ready port.
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   start       tile start, same cycle the feeder drives its first word
//   col_in      packed bottom-row PE outputs, column 0 in the LSBs
//   out_row     aligned row at the FIFO head (zero when empty)
//   out_valid   FIFO not empty
//   out_ready   consumer accepts; pop on out_valid && out_ready
//   busy        tile in progress (waiting or collecting rows)
//   tile_done   one-cycle pulse once the last row of a tile is stored
//   overflow    sticky: a row was dropped on a full FIFO
//   fifo_count  rows held
module tpu_result_deskew
  import tpu_pkg::*;
#(
  parameter int DEPTH      = TPU_DEPTH,
  parameter int DATA_W     = TPU_DATA_W,
  parameter int LATENCY    = 6,
  parameter int ROWS       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [DATA_W*DEPTH-1:0]       col_in,
  output logic [DATA_W*DEPTH-1:0]       out_row,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          tile_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  // Cycles spent in WAIT so that COLLECT lines up with the first aligned row.
  localparam int WAIT_LOAD = LATENCY + DEPTH - 2;
  localparam int CW        = (WAIT_LOAD > 1) ? $clog2(WAIT_LOAD + 1) : 1;
  localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_t                   state;
  state_t                   state_n;
  logic [CW-1:0]            cnt;
  logic [CW-1:0]            cnt_n;
  logic [RW-1:0]            row;
  logic [RW-1:0]            row_n;
  logic                     push;
  logic                     pop;
  logic                     full;
  logic                     empty;
  logic [DATA_W*DEPTH-1:0]  aligned;

  // Column c arrives c cycles after column 0 of the same row, so it is held
  // for DEPTH-1-c cycles; every column of a row then lines up with the
  // undelayed last column. The lines run every cycle regardless of state.
  for (genvar c = 0; c < DEPTH - 1; c++) begin : g_col
    localparam int N = DEPTH - 1 - c;
    logic [DATA_W-1:0] pipe [N];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < N; i++) begin
          pipe[i] <= '0;
        end
      end else begin
        pipe[0] <= col_in[c*DATA_W +: DATA_W];
        for (int i = 1; i < N; i++) begin
          pipe[i] <= pipe[i-1];
        end
      end
    end

    assign aligned[c*DATA_W +: DATA_W] = pipe[N-1];
  end
  assign aligned[(DEPTH-1)*DATA_W +: DATA_W] = col_in[(DEPTH-1)*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      row       <= '0;
      tile_done <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      row       <= row_n;
      // Registered, so the pulse follows the DONE cycle and a restart
      // accepted in DONE does not suppress it.
      tile_done <= (state == DONE);
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    row_n   = row;
    push    = 1'b0;
    busy    = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (start) begin
          row_n = '0;
          if (WAIT_LOAD == 0) begin
            state_n = COLLECT;
          end else begin
            state_n = WAIT;
            cnt_n   = CW'(WAIT_LOAD);
          end
        end
      end
      WAIT: begin
        busy  = 1'b1;
        cnt_n = cnt - CW'(1);
        // Leave as the count reaches zero so row 0 is pushed in its
        // alignment cycle.
        if (cnt <= CW'(1)) begin
          state_n = COLLECT;
        end
      end
      COLLECT: begin
        busy = 1'b1;
        push = 1'b1;
        if (row == RW'(ROWS - 1)) begin
          state_n = DONE;
        end else begin
          row_n = row + RW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign pop       = out_valid && out_ready;
  assign out_valid = !empty;

  tpu_row_fifo #(
    .WIDTH      (DATA_W * DEPTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (aligned),
    .pop       (pop),
    .head      (out_row),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_tpu_result_deskew.sv
// tb/tb_tpu_result_deskew.sv - self-checking bench for tpu_result_deskew
//
// Two instances run side by side: "a" with 4 rows per tile, "b" with 6 rows
// per tile so that a tile can exceed the FIFO. A tile-level model predicts
// every output every cycle; directed literals pin key points of the model.
module tb_tpu_result_deskew;

  localparam int L  = 6;
  localparam int D  = 4;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic        ready_a, ready_b;
  logic [31:0] col_a, col_b;
  logic [31:0] row_a, row_b;
  logic        valid_a, valid_b;
  logic        busy_a, busy_b;
  logic        td_a, td_b;
  logic        ovf_a, ovf_b;
  logic [2:0]  cnt_a, cnt_b;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  // Model state, one slot per instance.
  int          k_acc [2] = '{-1000, -1000};
  int          ntile [2] = '{0, 0};
  logic [7:0]  mbase [2];
  logic [31:0] mq    [2][FD];
  int          mcnt  [2] = '{0, 0};
  bit          movf  [2];
  bit          exp_td   [2];
  bit          exp_busy [2];

  initial forever #5 clk = ~clk;

  tpu_result_deskew #(.DEPTH(D), .DATA_W(8), .LATENCY(L), .ROWS(4), .FIFO_DEPTH(FD)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .col_in(col_a), .out_row(row_a),
    .out_valid(valid_a), .out_ready(ready_a), .busy(busy_a), .tile_done(td_a),
    .overflow(ovf_a), .fifo_count(cnt_a)
  );

  tpu_result_deskew #(.DEPTH(D), .DATA_W(8), .LATENCY(L), .ROWS(6), .FIFO_DEPTH(FD)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .col_in(col_b), .out_row(row_b),
    .out_valid(valid_b), .out_ready(ready_b), .busy(busy_b), .tile_done(td_b),
    .overflow(ovf_b), .fifo_count(cnt_b)
  );

  function automatic int rows_of(input int m);
    return (m == 0) ? 4 : 6;
  endfunction

  // Column c of row r in a tile carries base + 0x10*r + c.
  function automatic logic [31:0] row_val(input int r, input logic [7:0] base);
    logic [31:0] v;
    for (int c = 0; c < D; c++) v[c*8 +: 8] = base + 8'(16 * r + c);
    return v;
  endfunction

  // Skewed input word for cycle t: row r column c appears in k+L+r+c.
  function automatic logic [31:0] gen_col(input int m, input int t);
    logic [31:0] v;
    int r;
    for (int c = 0; c < D; c++) begin
      r = t - k_acc[m] - L - c;
      if (r >= 0 && r < rows_of(m)) v[c*8 +: 8] = mbase[m] + 8'(16 * r + c);
      else v[c*8 +: 8] = 8'hEE;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Tile-level model: a tile started at k pushes row r at the end of cycle
  // k+L+D-1+r, is busy from k+1 through its last push, and reports done two
  // cycles after its last push. The FIFO is a plain list with pop first.
  task automatic model_step(input int m, input logic st, input logic rdy);
    int  r;
    int  rows;
    bit  pop_now;
    bit  busy_now;
    rows = rows_of(m);
    if (rst) begin
      mcnt[m] = 0; movf[m] = 0; k_acc[m] = -1000; exp_td[m] = 0; exp_busy[m] = 0;
      return;
    end
    exp_td[m] = (cyc == k_acc[m] + L + D - 1 + rows);
    pop_now = (mcnt[m] > 0) && rdy;
    if (pop_now) begin
      for (int i = 0; i < FD - 1; i++) mq[m][i] = mq[m][i+1];
      mcnt[m]--;
    end
    r = cyc - k_acc[m] - (L + D - 1);
    if (r >= 0 && r < rows) begin
      if (mcnt[m] < FD) begin
        mq[m][mcnt[m]] = row_val(r, mbase[m]);
        mcnt[m]++;
      end else begin
        movf[m] = 1;
      end
    end
    busy_now = (cyc >= k_acc[m] + 1) && (cyc <= k_acc[m] + L + D - 2 + rows);
    if (st && !busy_now) begin
      k_acc[m] = cyc;
      mbase[m] = (ntile[m] % 2 == 1) ? 8'h80 : 8'h00;
      ntile[m]++;
    end
    exp_busy[m] = (cyc + 1 >= k_acc[m] + 1) && (cyc + 1 <= k_acc[m] + L + D - 2 + rows);
  endtask

  task automatic cmp_inst(input string tag, input int m, input logic [31:0] row,
                          input logic valid, input logic busy, input logic td,
                          input logic ovf, input logic [2:0] cnt);
    chk({tag, ".out_valid"}, 32'(valid), 32'(mcnt[m] > 0));
    chk({tag, ".out_row"}, row, (mcnt[m] > 0) ? mq[m][0] : 32'h0);
    chk({tag, ".fifo_count"}, 32'(cnt), 32'(mcnt[m]));
    chk({tag, ".busy"}, 32'(busy), 32'(exp_busy[m]));
    chk({tag, ".tile_done"}, 32'(td), 32'(exp_td[m]));
    chk({tag, ".overflow"}, 32'(ovf), 32'(movf[m]));
  endtask

  initial forever begin
    @(posedge clk);
    model_step(0, start_a, ready_a);
    model_step(1, start_b, ready_b);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (cyc >= 1) begin
      cmp_inst("a", 0, row_a, valid_a, busy_a, td_a, ovf_a, cnt_a);
      cmp_inst("b", 1, row_b, valid_b, busy_b, td_b, ovf_b, cnt_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    col_a   = gen_col(0, cyc);
    col_b   = gen_col(1, cyc);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic goto_cycle(input int n);
    while (cyc < n) tick();
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    ready_a = 1'b1; ready_b = 1'b0;
    col_a = 32'hEEEEEEEE; col_b = 32'hEEEEEEEE;
    goto_cycle(3);  rst = 1'b0;

    // Tile 1 on both; b is backpressured and overflows.
    goto_cycle(10); start_a = 1'b1; start_b = 1'b1;
    goto_cycle(14); start_a = 1'b1;
    goto_cycle(20); @(negedge clk); chk("lit.a.row0", row_a, 32'h03020100);
    goto_cycle(21); @(negedge clk); chk("lit.a.row1", row_a, 32'h13121110);
    goto_cycle(22); @(negedge clk); chk("lit.a.row2", row_a, 32'h23222120);
    goto_cycle(23); @(negedge clk);
    chk("lit.a.row3", row_a, 32'h33323130);
    chk("lit.b.count_full", 32'(cnt_b), 32'd4);
    chk("lit.b.no_ovf_yet", 32'(ovf_b), 32'd0);
    goto_cycle(24); start_a = 1'b1; @(negedge clk);
    chk("lit.a.tile_done", 32'(td_a), 32'd1);
    chk("lit.a.drained", 32'(valid_a), 32'd0);
    goto_cycle(25); @(negedge clk);
    chk("lit.b.overflow", 32'(ovf_b), 32'd1);
    chk("lit.b.head", row_b, 32'h03020100);
    goto_cycle(30); ready_b = 1'b1;
    goto_cycle(33); @(negedge clk); chk("lit.b.last_drain", row_b, 32'h33323130);
    goto_cycle(34); @(negedge clk);
    chk("lit.b.empty", 32'(valid_b), 32'd0);
    chk("lit.b.ovf_sticky", 32'(ovf_b), 32'd1);
    chk("lit.a.tile2_row0", row_a, 32'h83828180);
    goto_cycle(36); ready_b = 1'b0;

    // Tile abandoned by reset mid-flight.
    goto_cycle(45); start_a = 1'b1; start_b = 1'b1;
    goto_cycle(56); rst = 1'b1;
    goto_cycle(57); rst = 1'b0; @(negedge clk);
    chk("lit.rst.valid", 32'(valid_a), 32'd0);
    chk("lit.rst.busy", 32'(busy_a), 32'd0);
    chk("lit.rst.count", 32'(cnt_a), 32'd0);
    chk("lit.rst.ovf_cleared", 32'(ovf_b), 32'd0);
    goto_cycle(59); @(negedge clk); chk("lit.rst.no_done", 32'(td_a), 32'd0);

    // Restart after reset; b fills and is then drained while still pushing.
    goto_cycle(65); start_a = 1'b1; start_b = 1'b1;
    goto_cycle(75); @(negedge clk); chk("lit.a.after_rst_row0", row_a, 32'h83828180);
    goto_cycle(78); ready_b = 1'b1; start_a = 1'b1;
    goto_cycle(79); @(negedge clk);
    chk("lit.a.done_with_restart", 32'(td_a), 32'd1);
    chk("lit.b.full_pushpop", 32'(cnt_b), 32'd4);
    goto_cycle(80); @(negedge clk);
    chk("lit.b.full_pushpop2", 32'(cnt_b), 32'd4);
    chk("lit.b.no_ovf_pushpop", 32'(ovf_b), 32'd0);
    chk("lit.b.order_row2", row_b, 32'h23222120);
    goto_cycle(82); @(negedge clk); chk("lit.b.order_row4", row_b, 32'h43424140);
    goto_cycle(84); @(negedge clk); chk("lit.b.drained", 32'(valid_b), 32'd0);
    goto_cycle(88); @(negedge clk); chk("lit.a.b2b_row0", row_a, 32'h03020100);

    goto_cycle(100);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
